// File: rtl/adc_pkg.sv
// Shared types and constants for the LTC2308 scan controller.
package adc_pkg;

   typedef enum logic [1:0] {
      S_CONV,
      S_WAIT,
      S_SHIFT,
      S_STORE
   } state_e;

   localparam int   ADC_RES_W = 12;
   localparam logic CFG_SD    = 1'b1;
   localparam logic CFG_UNI   = 1'b1;
   localparam logic CFG_SLP   = 1'b0;

   // LTC2308 channel select bits are ordered O/S, S1, S0.
   function automatic logic [5:0] cfg_word(input logic [2:0] ch);
      return {CFG_SD, ch[0], ch[2], ch[1], CFG_UNI, CFG_SLP};
   endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// SCK divider for the ADC shift phase: low half first, counts rising edges.
module adc_sck_gen
   import adc_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   output logic       sck_o,
   output logic       rise_o,
   output logic       fall_o,
   output logic [3:0] edge_cnt_o
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div_q, div_d;
   logic          sck_q, sck_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          tick;

   assign tick       = en_i && (div_q == DW'(CLK_DIV - 1));
   assign rise_o     = tick & ~sck_q;
   assign fall_o     = tick & sck_q;
   assign sck_o      = sck_q;
   assign edge_cnt_o = cnt_q;

   always_comb begin
      div_d = div_q;
      sck_d = sck_q;
      cnt_d = cnt_q;
      if (!en_i) begin
         div_d = '0;
         sck_d = 1'b0;
         cnt_d = '0;
      end else if (tick) begin
         div_d = '0;
         sck_d = ~sck_q;
         if (!sck_q) cnt_d = cnt_q + 4'd1;
      end else begin
         div_d = div_q + DW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         sck_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         div_q <= div_d;
         sck_q <= sck_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Free-running LTC2308 scan controller holding the latest code per channel.
// Optional ADC_AVG_EN: each channel register keeps a 2-tap running average.
module adc_scan_ctrl
   import adc_pkg::*;
#(
   parameter int CLK_DIV     = 2,
   parameter int CONV_CYCLES = 80,
   parameter int NUM_CH      = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 ADC_CONVST,
   output logic                 ADC_SCK,
   output logic                 ADC_SDI,
   input  logic                 ADC_SDO,
   output logic [ADC_RES_W-1:0] ch0,
   output logic [ADC_RES_W-1:0] ch1,
   output logic [ADC_RES_W-1:0] ch2,
   output logic [ADC_RES_W-1:0] ch3,
   output logic [ADC_RES_W-1:0] ch4,
   output logic [ADC_RES_W-1:0] ch5,
   output logic                 sample_valid,
   output logic [2:0]           sample_ch,
   output logic                 scan_done
);

   localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

   state_e               state_q, state_d;
   logic [15:0]          cnt_q, cnt_d;
   logic                 convst_q, convst_d;
   logic                 sdi_q, sdi_d;
   logic                 primed_q, primed_d;
   logic                 valid_q, valid_d;
   logic                 done_q, done_d;
   logic [2:0]           cfg_q, cfg_d;
   logic [2:0]           prev_q, prev_d;
   logic [2:0]           sch_q, sch_d;
   logic [ADC_RES_W-1:0] sh_q, sh_d;
   logic [ADC_RES_W-1:0] ch_q [6];
   logic [ADC_RES_W-1:0] ch_d [6];
`ifdef ADC_AVG_EN
   logic [5:0]           loaded_q, loaded_d;
   logic [ADC_RES_W:0]   sum;
`endif

   logic       sck_en, sck_rise, sck_fall, sck;
   logic [3:0] edge_cnt;
   logic [5:0] cfg_w;
   logic [2:0] bit_idx;

   assign sck_en  = (state_q == S_SHIFT);
   assign cfg_w   = cfg_word(cfg_q);
   assign bit_idx = 3'(4'd5 - edge_cnt);

   adc_sck_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_sck (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (sck_en),
      .sck_o     (sck),
      .rise_o    (sck_rise),
      .fall_o    (sck_fall),
      .edge_cnt_o(edge_cnt)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      convst_d = 1'b0;
      sdi_d    = 1'b0;
      primed_d = primed_q;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      cfg_d    = cfg_q;
      prev_d   = prev_q;
      sch_d    = sch_q;
      sh_d     = sh_q;
      ch_d     = ch_q;
`ifdef ADC_AVG_EN
      loaded_d = loaded_q;
      sum      = '0;
`endif
      unique case (state_q)
         S_CONV: begin
            convst_d = 1'b1;
            sh_d     = '0;
            if (cnt_q == 16'd1) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_WAIT: begin
            if (cnt_q == 16'(CONV_CYCLES - 1)) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
               sdi_d   = cfg_w[5];
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_SHIFT: begin
            sdi_d = sdi_q;
            if (sck_rise) sh_d = {sh_q[ADC_RES_W-2:0], ADC_SDO};
            // Next config bit goes out on the falling edge ahead of its rise.
            if (sck_fall) begin
               sdi_d = (edge_cnt < 4'd6) ? cfg_w[bit_idx] : 1'b0;
               if (edge_cnt == 4'd12) state_d = S_STORE;
            end
         end
         S_STORE: begin
            state_d = S_CONV;
            if (primed_q) begin
               valid_d = 1'b1;
               sch_d   = prev_q;
               done_d  = (prev_q == LAST_CH);
               for (int i = 0; i < 6; i++) begin
                  if (i < NUM_CH && prev_q == 3'(i)) begin
`ifdef ADC_AVG_EN
                     sum = {1'b0, ch_q[i]} + {1'b0, sh_q} + 13'd1;
                     ch_d[i]     = loaded_q[i] ? sum[ADC_RES_W:1] : sh_q;
                     loaded_d[i] = 1'b1;
`else
                     ch_d[i] = sh_q;
`endif
                  end
               end
            end
            primed_d = 1'b1;
            prev_d   = cfg_q;
            cfg_d    = (cfg_q == LAST_CH) ? 3'd0 : cfg_q + 3'd1;
         end
         default: state_d = S_CONV;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_CONV;
         cnt_q    <= '0;
         convst_q <= 1'b0;
         sdi_q    <= 1'b0;
         primed_q <= 1'b0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         cfg_q    <= '0;
         prev_q   <= '0;
         sch_q    <= '0;
         sh_q     <= '0;
         for (int i = 0; i < 6; i++) ch_q[i] <= '0;
`ifdef ADC_AVG_EN
         loaded_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         convst_q <= convst_d;
         sdi_q    <= sdi_d;
         primed_q <= primed_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         cfg_q    <= cfg_d;
         prev_q   <= prev_d;
         sch_q    <= sch_d;
         sh_q     <= sh_d;
         for (int i = 0; i < 6; i++) ch_q[i] <= ch_d[i];
`ifdef ADC_AVG_EN
         loaded_q <= loaded_d;
`endif
      end
   end

   assign ADC_CONVST   = convst_q;
   assign ADC_SCK      = sck;
   assign ADC_SDI      = sdi_q;
   assign sample_valid = valid_q;
   assign sample_ch    = sch_q;
   assign scan_done    = done_q;
   assign ch0          = ch_q[0];
   assign ch1          = ch_q[1];
   assign ch2          = ch_q[2];
   assign ch3          = ch_q[3];
   assign ch4          = ch_q[4];
   assign ch5          = ch_q[5];

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Free-running scan controller for the board's LTC2308 8-channel 12-bit SPI ADC. It sequences conversions on channels 0..5, shifts results in, and holds the latest 12-bit code per channel. It sits directly upstream of the wire-sensing memory-mapped read port, which muxes `ch0`..`ch5` onto the bus.

## Interface
- `CLK_DIV`, 2: clk cycles per SCK half-period; legal range ≥1.
- `CONV_CYCLES`, 80: clk cycles waited for conversion; 1.6 µs at 50 MHz.
- `NUM_CH`, 6: channels scanned, 0..NUM_CH-1; legal range 1..8.
- `clk` input 1: system clock, 50 MHz.
- `rst_n` input 1: asynchronous, active-low reset.
- `ADC_CONVST` output 1: conversion start.
- `ADC_SCK` output 1: serial clock.
- `ADC_SDI` output 1: 6-bit config word, MSB first.
- `ADC_SDO` input 1: serial result, MSB first.
- `ch0`..`ch5` output 12 each: latest code per channel.
- `sample_valid` output 1: one-cycle pulse when a channel register updates.
- `sample_ch` output 3: index of the channel updated; valid with `sample_valid`.
- `scan_done` output 1: one-cycle pulse, coincident with the update of channel NUM_CH-1.

## Operation
- FSM states are CONV, WAIT, SHIFT and STORE:
  - CONV → WAIT → SHIFT → STORE → CONV, looping forever.
  - No idle state; the first CONV starts on the first clk edge after `rst_n` deasserts.
- Each frame k sends the config for `cfg_ch` = k mod NUM_CH.
- Config word is {S/D=1, O/S=cfg_ch[0], S1=cfg_ch[2], S0=cfg_ch[1], UNI=1, SLP=0}:
  - ch0 = 100010
  - ch1 = 110010
  - ch2 = 100110
- The data shifted in during frame k belongs to the channel configured in frame k-1 (ADC pipeline).
  - The store target is `prev_ch`.
  - The frame after reset has no valid predecessor: its data is discarded and no store or `sample_valid` occurs (`primed` flag).
- SDI:
  - Drive config bit i (MSB first) before SCK rising edge i, for i = 0..5.
  - SDI = 0 for edges 6..11.
- SDO: sampled at each SCK rising edge, 12 edges, shifted MSB first.
- STORE:
  - Write the shift register into `ch[prev_ch]`.
  - Pulse `sample_valid` with `sample_ch = prev_ch`.
  - Pulse `scan_done` if `prev_ch == NUM_CH-1`.
  - Set `prev_ch = cfg_ch`; advance `cfg_ch` with wrap NUM_CH-1 → 0.
- Outputs for channels ≥ NUM_CH stay 0.
- Reset values:
  - `ch0`..`ch5` = 0.
  - `ADC_CONVST`, `ADC_SCK`, `ADC_SDI`, `sample_valid`, `scan_done` = 0.
  - `sample_ch` = 0.
  - `cfg_ch` = 0, `primed` = 0.
- Reset mid-frame: all state and outputs return to reset values asynchronously; the partial word is discarded; priming repeats.

## Timing
- CONV: `ADC_CONVST` = 1 for 2 clk cycles.
- WAIT: CONV_CYCLES cycles; SCK and CONVST low.
- SHIFT:
  - 12 SCK periods, each CLK_DIV cycles low then CLK_DIV cycles high; 24·CLK_DIV cycles total.
  - SCK is low on entry and on exit.
  - SDI changes only while SCK is low.
- STORE: 1 cycle. Registered outputs and pulses are visible on the cycle after STORE.
- Frame length F = 3 + CONV_CYCLES + 24·CLK_DIV; with defaults, F = 131 clk cycles.
- Latency from a conversion to its register update: 2 frames minus the unused portion.
- Full scan period: NUM_CH·F.
- All outputs are registered; no combinational path from `ADC_SDO` to outputs.

## Configuration
- `ADC_AVG_EN` defined:
  - Each channel register holds a 2-tap running average, `ch = (ch + sample + 1) >> 1`, computed in 13 bits.
  - The first store per channel after reset loads `sample` directly (per-channel `loaded` bit).
- `ADC_AVG_EN` undefined: STORE writes the raw sample and no `loaded` bits exist.

## Structure
- Package `adc_pkg` holds:
  - the FSM state enum;
  - `ADC_RES_W` = 12;
  - `CFG_SD` = 1, `CFG_UNI` = 1, `CFG_SLP` = 0;
  - the function building the 6-bit config word from a 3-bit channel index.
- One sub-module, `adc_sck_gen`:
  - CLK_DIV divider, enabled in SHIFT;
  - emits `sck`, a `rise` strobe, a `fall` strobe and an edge count 0..12.

## Test plan
- Release reset → `ADC_CONVST` high for 2 cycles starting 1 cycle after release; frame-0 SDI bits = 1,0,0,0,1,0; no `sample_valid` during frame 0.
- ADC model returns 12'h100 + 12'h111·ch → after 7 frames `ch0`..`ch5` = 100, 211, 322, 433, 544, 655; `sample_ch` pulses in order 0..5.
- Defaults → exactly 12 SCK rising edges per frame, SCK period 4 clk, CONVST-to-CONVST distance 131 cycles.
- Wrap → `scan_done` pulses together with the `sample_ch` = 5 update; the next store targets ch0; repeated over 3 scans.
- Assert `rst_n` during the 5th SCK edge → all outputs 0 in the same cycle; after release the first frame is discarded again and ch0 config is resent.
- `ADC_AVG_EN` defined, ch2 receives 12'h100 then 12'h201 → `ch2` = 12'h100, then 12'h181.
